// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the tinylabcpu datapath.
// Drives the ALU operand stage and register-file strobes; halts on HALT or ALU timeout.
module cpu_ctrl_fsm #(
  parameter int PC_W    = 8,
  parameter int ALU_TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     imem_q,
  input  logic            alu_done,
  input  logic            zero_flag,
  output logic            imem_rd,
  output logic [PC_W-1:0] pc,
  output logic            alu_en,
  output logic            alu_in_sel,
  output logic [1:0]      alu_op,
  output logic [7:0]      offset,
  output logic [2:0]      rd_addr,
  output logic [2:0]      rs_addr,
  output logic            rd_we,
  output logic            busy,
  output logic            halted,
  output logic            err_illegal,
  output logic            err_tmo,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_WB, S_HALTED
  } state_t;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0, OP_HALT = 5'd1, OP_ADD = 5'd2, OP_ADDI = 5'd3,
    OP_SUB  = 5'd4, OP_SUBI = 5'd5, OP_AND = 5'd6, OP_OR   = 5'd7,
    OP_JMP  = 5'd8, OP_BZ   = 5'd9
  } opcode_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [15:0]     r_ir, w_ir_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [15:0]     r_retired;
  logic            r_err_illegal, r_err_tmo;
  logic            w_retire, w_set_ill, w_set_tmo;
  logic [4:0]      w_q_op, w_ir_op;

  assign w_q_op   = imem_q[15:11];
  assign w_ir_op  = r_ir[15:11];
  assign w_pc_inc = r_pc + PC_W'(1);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    w_retire    = 1'b0;
    w_set_ill   = 1'b0;
    w_set_tmo   = 1'b0;
    unique case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_ir_nxt = imem_q;
        case (w_q_op)
          OP_NOP: begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
          OP_HALT: begin
            w_state_nxt = S_HALTED;
            w_retire    = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR:
            w_state_nxt = S_EXEC;
          OP_JMP: begin
            w_pc_nxt    = imem_q[PC_W-1:0];
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
          OP_BZ: begin
            w_pc_nxt    = zero_flag ? PC_W'(imem_q[7:0]) : w_pc_inc;
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
          default: begin
            // Illegal opcodes behave as NOP but leave a sticky flag behind.
            w_set_ill   = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          w_state_nxt = S_WB;
        end else if (r_cnt == 8'(ALU_TMO - 1)) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_HALTED;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WB: begin
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
        w_retire    = 1'b1;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_ir          <= '0;
      r_cnt         <= '0;
      r_retired     <= '0;
      r_err_illegal <= 1'b0;
      r_err_tmo     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_set_ill) r_err_illegal <= 1'b1;
      if (w_set_tmo) r_err_tmo     <= 1'b1;
      if (w_retire && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
    end
  end

  // Operand fields decode straight from ir, so they hold from EXEC until the next DECODE.
  always_comb begin
    alu_op     = 2'd0;
    alu_in_sel = 1'b0;
    case (w_ir_op)
      OP_ADD:  begin alu_op = 2'd0; alu_in_sel = 1'b1; end
      OP_ADDI: alu_op = 2'd0;
      OP_SUB:  begin alu_op = 2'd1; alu_in_sel = 1'b1; end
      OP_SUBI: alu_op = 2'd1;
      OP_AND:  begin alu_op = 2'd2; alu_in_sel = 1'b1; end
      OP_OR:   begin alu_op = 2'd3; alu_in_sel = 1'b1; end
      default: begin alu_op = 2'd0; alu_in_sel = 1'b0; end
    endcase
  end

  assign offset      = r_ir[7:0];
  assign rd_addr     = r_ir[10:8];
  assign rs_addr     = r_ir[7:5];
  assign imem_rd     = (r_state == S_FETCH);
  assign alu_en      = (r_state == S_EXEC);
  assign rd_we       = (r_state == S_WB);
  assign halted      = (r_state == S_HALTED);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign pc          = r_pc;
  assign retired     = r_retired;
  assign err_illegal = r_err_illegal;
  assign err_tmo     = r_err_tmo;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed programs plus a random instruction
// stream checked against an instruction-level model of pc, retire count and flags.
module tb_cpu_ctrl_fsm;
  localparam int PC_W = 8;
  localparam int TMO  = 15;

  logic            clk, rst, start, alu_done, zero_flag;
  logic [15:0]     imem_q;
  logic            imem_rd, alu_en, alu_in_sel, rd_we, busy, halted, err_illegal, err_tmo;
  logic [PC_W-1:0] pc;
  logic [1:0]      alu_op;
  logic [7:0]      offset;
  logic [2:0]      rd_addr, rs_addr;
  logic [15:0]     retired;

  logic [15:0]     mem [256];
  logic [PC_W-1:0] exp_pc;
  logic [15:0]     exp_retired;
  logic            exp_ill;
  int              n_checks, n_err;

  cpu_ctrl_fsm #(.PC_W(PC_W), .ALU_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_q(imem_q), .alu_done(alu_done),
    .zero_flag(zero_flag), .imem_rd(imem_rd), .pc(pc), .alu_en(alu_en),
    .alu_in_sel(alu_in_sel), .alu_op(alu_op), .offset(offset), .rd_addr(rd_addr),
    .rs_addr(rs_addr), .rd_we(rd_we), .busy(busy), .halted(halted),
    .err_illegal(err_illegal), .err_tmo(err_tmo), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_alu(input logic [4:0] op);
    return (op >= 5'd2) && (op <= 5'd7);
  endfunction

  function automatic logic [1:0] exp_alu_op(input logic [4:0] op);
    case (op)
      5'd2, 5'd3: return 2'd0;
      5'd4, 5'd5: return 2'd1;
      5'd6:       return 2'd2;
      5'd7:       return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic logic exp_sel(input logic [4:0] op);
    return (op == 5'd2) || (op == 5'd4) || (op == 5'd6) || (op == 5'd7);
  endfunction

  function automatic logic [15:0] rand_instr();
    int         k;
    logic [4:0] op;
    k = $urandom_range(0, 9);
    if (k == 0)      op = 5'd0;
    else if (k <= 6) op = 5'(k + 1);
    else if (k == 7) op = 5'd8;
    else if (k == 8) op = 5'd9;
    else             op = 5'($urandom_range(10, 31));
    return {op, 11'($urandom)};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_imem_rd"}, imem_rd, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_alu_en"}, alu_en, 0);
    chk({tag, "_sel"}, alu_in_sel, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_offset"}, offset, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rs_addr"}, rs_addr, 0);
    chk({tag, "_rd_we"}, rd_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err_ill"}, err_illegal, 0);
    chk({tag, "_err_tmo"}, err_tmo, 0);
    chk({tag, "_retired"}, retired, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_idle("rst");
    tick();
    rst = 1'b1;
    exp_pc = '0; exp_retired = '0; exp_ill = 1'b0;
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle. zsel<0: random zero_flag.
  // dly>0: alu_done after dly WAIT_ALU cycles; dly==0: never (timeout); dly<0: reset mid-wait.
  task automatic exec_one(input int zsel, input int dly);
    logic [15:0] w;
    logic [4:0]  op;
    logic        z;
    int          n;
    n = 0;
    while (!imem_rd && n < 20) begin tick(); n++; end
    chk("fetch_seen", imem_rd, 1);
    chk("fetch_pc", pc, exp_pc);
    chk("fetch_busy", busy, 1);
    chk("fetch_retired", retired, exp_retired);
    chk("fetch_err_ill", err_illegal, exp_ill);
    w = mem[exp_pc];
    op = w[15:11];
    imem_q = 16'($urandom);
    zero_flag = 1'($urandom);
    tick();
    z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    imem_q = w;
    zero_flag = z;
    chk("decode_imem_rd", imem_rd, 0);
    chk("decode_alu_en", alu_en, 0);
    tick();
    imem_q = 16'($urandom);
    if (is_alu(op)) begin
      chk("exec_alu_en", alu_en, 1);
      chk("exec_sel", alu_in_sel, exp_sel(op));
      chk("exec_op", alu_op, exp_alu_op(op));
      chk("exec_offset", offset, w[7:0]);
      chk("exec_rd", rd_addr, w[10:8]);
      chk("exec_rs", rs_addr, w[7:5]);
      alu_done = 1'($urandom);
      tick();
      alu_done = 1'b0;
      if (dly == 0) begin
        for (int i = 0; i < TMO; i++) begin
          chk("tmo_wait_alu_en", alu_en, 0);
          chk("tmo_wait_rd_we", rd_we, 0);
          chk("tmo_wait_halted", halted, 0);
          tick();
        end
        chk("tmo_halted", halted, 1);
        chk("tmo_err", err_tmo, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_rd_we", rd_we, 0);
        chk("tmo_retired", retired, exp_retired);
      end else if (dly < 0) begin
        tick();
        rst = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        rst = 1'b1;
        exp_pc = '0; exp_retired = '0; exp_ill = 1'b0;
        alu_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
          tick();
          alu_done = 1'b0;
          chk("post_rst_rd_we", rd_we, 0);
          chk("post_rst_busy", busy, 0);
        end
      end else begin
        for (int i = 1; i <= dly; i++) begin
          alu_done = (i == dly);
          chk("wait_alu_en", alu_en, 0);
          chk("wait_rd_we", rd_we, 0);
          tick();
        end
        alu_done = 1'($urandom);
        chk("wb_rd_we", rd_we, 1);
        chk("wb_sel", alu_in_sel, exp_sel(op));
        chk("wb_op", alu_op, exp_alu_op(op));
        chk("wb_offset", offset, w[7:0]);
        chk("wb_rd", rd_addr, w[10:8]);
        chk("wb_rs", rs_addr, w[7:5]);
        exp_pc = exp_pc + 1'b1;
        exp_retired = exp_retired + 16'd1;
        tick();
        alu_done = 1'b0;
        chk("after_wb_rd_we", rd_we, 0);
      end
    end else if (op == 5'd1) begin
      exp_retired = exp_retired + 16'd1;
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_retired", retired, exp_retired);
      chk("halt_pc", pc, exp_pc);
    end else begin
      chk("ctl_alu_en", alu_en, 0);
      if (op == 5'd8)                  exp_pc = w[PC_W-1:0];
      else if (op == 5'd9 && z)        exp_pc = w[7:0];
      else                             exp_pc = exp_pc + 1'b1;
      if (op >= 5'd10) exp_ill = 1'b1;
      exp_retired = exp_retired + 16'd1;
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; imem_q = '0; alu_done = 1'b0; zero_flag = 1'b0;
    exp_pc = '0; exp_retired = '0; exp_ill = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("idle");

    // Directed program: ADDI, ADD, BZ taken, BZ not taken, JMP, illegal, NOP, HALT.
    mem[8'h00] = 16'h1905; mem[8'h01] = 16'h1260; mem[8'h02] = 16'h4810;
    mem[8'h10] = 16'h4810; mem[8'h11] = 16'h4040; mem[8'h40] = 16'hF800;
    mem[8'h41] = 16'h0000; mem[8'h42] = 16'h0800;
    start_pulse();
    exec_one(-1, 1);
    chk("addi_pc", pc, 1);
    chk("addi_retired", retired, 1);
    exec_one(-1, 2);
    exec_one(1, 1);
    chk("bz_taken_pc", pc, 8'h10);
    exec_one(0, 1);
    chk("bz_not_taken_pc", pc, 8'h11);
    exec_one(-1, 1);
    chk("jmp_pc", pc, 8'h40);
    exec_one(-1, 1);
    chk("illegal_flag", err_illegal, 1);
    chk("illegal_pc", pc, 8'h41);
    exec_one(-1, 1);
    exec_one(-1, 1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("halted_start_halted", halted, 1);
      chk("halted_start_imem_rd", imem_rd, 0);
      chk("halted_start_pc", pc, exp_pc);
      chk("halted_start_retired", retired, 8);
    end

    // ALU timeout.
    do_reset();
    mem[8'h00] = 16'h1260;
    start_pulse();
    exec_one(-1, 0);

    // Reset asserted while waiting for the ALU.
    do_reset();
    mem[8'h00] = 16'h1905;
    start_pulse();
    exec_one(-1, -1);

    // pc wrap: JMP 0xFF then NOP at 0xFF.
    do_reset();
    mem[8'h00] = 16'h40FF;
    mem[8'hFF] = 16'h0000;
    start_pulse();
    exec_one(-1, 1);
    exec_one(-1, 1);
    chk("wrap_pc", pc, 8'h00);

    // Random instruction stream against the model.
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    for (int i = 0; i < 200; i++) exec_one(-1, $urandom_range(1, 4));
    chk("rand_retired", retired, exp_retired);
    chk("rand_err_ill", err_illegal, exp_ill);
    chk("rand_err_tmo", err_tmo, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
